cache_main_memory: RTL and testbench

Block-granular main memory that sits behind the 2-way write-back cache and answers its miss refills and dirty-block write-backs. It accepts one 128-bit block request at a time over a valid/ready handshake, waits a programmable access latency, performs the read or write, and returns a one-cycle response pulse. It replaces the zero-latency combinational memory, so cache controllers must run a real refill and write-back state machine.

---
 rtl/cache_main_memory.sv | 106 ++++++++++
 tb/tb_cache_main_memory.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cache_main_memory.sv
// Block-granular backing memory for the write-back cache.
// One 128-bit request at a time, fixed access latency, one-cycle response.
module cache_main_memory #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [127:0]      resp_rdata
);

  localparam int BLK_W = ADDR_W - 4;
  localparam int WORDS = 1 << (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]      Memory [0:WORDS-1];
  logic [3:0]       cnt;
  logic             wr_q;
  logic [BLK_W-1:0] blk_q;
  logic [127:0]     wdata_q;
  logic             accept;
  logic             done;
  logic             unused_offset;

  assign unused_offset = ^req_addr[3:0];

  assign accept = req_valid && (state == IDLE);
  assign done   = (state == BUSY) && (cnt == 4'd0);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE): if (req_valid) state_nxt = BUSY;
      (state == BUSY): if (cnt == 4'd0) state_nxt = RESP;
      (state == RESP): state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      wr_q    <= 1'b0;
      blk_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY - 1);
      wr_q    <= req_write;
      blk_q   <= req_addr[ADDR_W-1:4];
      wdata_q <= req_wdata;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Writes echo the latched block so the response always reflects memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= '0;
    end else if (done) begin
      if (wr_q) begin
        resp_rdata <= wdata_q;
      end else begin
        resp_rdata <= {Memory[{blk_q, 2'd3}],
                       Memory[{blk_q, 2'd2}],
                       Memory[{blk_q, 2'd1}],
                       Memory[{blk_q, 2'd0}]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        Memory[i] <= 32'd0;
      end
    end else if (done && wr_q) begin
      for (int k = 0; k < 4; k++) begin
        Memory[{blk_q, 2'(k)}] <= wdata_q[32*k +: 32];
      end
    end
  end

endmodule

// File: tb/tb_cache_main_memory.sv
// Directed bench for cache_main_memory: latency, data path,
// handshake, reset abort and a LATENCY=1 instance.
module tb_cache_main_memory;

  logic         clk;
  logic         reset;

  logic         v0, w0;
  logic [9:0]   a0;
  logic [127:0] d0;
  logic         rdy0, rv0;
  logic [127:0] rd0;

  logic         v1, w1;
  logic [9:0]   a1;
  logic [127:0] d1;
  logic         rdy1, rv1;
  logic [127:0] rd1;

  int errors;
  int checks;

  localparam logic [127:0] DFF =
    128'h000000DD_000000CC_000000BB_000000FF;
  localparam logic [127:0] DA =
    128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D5 =
    128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
  localparam logic [127:0] DX =
    128'h0BADC0DE_12345678_9ABCDEF0_FEEDFACE;

  cache_main_memory #(.ADDR_W(10), .LATENCY(4)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (v0),
    .req_write  (w0),
    .req_addr   (a0),
    .req_wdata  (d0),
    .req_ready  (rdy0),
    .resp_valid (rv0),
    .resp_rdata (rd0)
  );

  cache_main_memory #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (v1),
    .req_write  (w1),
    .req_addr   (a1),
    .req_wdata  (d1),
    .req_ready  (rdy1),
    .resp_valid (rv1),
    .resp_rdata (rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request on dut0, then wait (bounded) for its response.
  task automatic txn0(input logic wr,
                      input logic [9:0] addr,
                      input logic [127:0] data);
    int n;
    chk("txn_ready", 128'(rdy0), 128'd1);
    v0 = 1'b1; w0 = wr; a0 = addr; d0 = data;
    step();
    v0 = 1'b0;
    n = 0;
    while (!rv0 && n < 20) begin
      step();
      n++;
    end
    chk("txn_latency", 128'(n), 128'd4);
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    v0 = 0; w0 = 0; a0 = '0; d0 = '0;
    v1 = 0; w1 = 0; a1 = '0; d1 = '0;
    step();
    step();
    reset = 1'b0;

    chk("rst_ready", 128'(rdy0), 128'd1);
    chk("rst_resp", 128'(rv0), 128'd0);
    chk("rst_rdata", rd0, 128'd0);
    chk("rst_mem0", 128'(dut0.Memory[0]), 128'd0);
    chk("rst_mem255", 128'(dut0.Memory[255]), 128'd0);

    // Read block 0: ready low 5 samples, pulse only after T0+4.
    v0 = 1'b1; w0 = 1'b0; a0 = 10'd0;
    step();
    v0 = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      chk($sformatf("rd0_ready_%0d", i), 128'(rdy0),
          128'(i == 5));
      chk($sformatf("rd0_resp_%0d", i), 128'(rv0),
          128'(i == 4));
      if (i < 5) step();
    end
    chk("rd0_rdata", rd0, 128'd0);

    // Write block 32, then read it back with a nonzero offset.
    txn0(1'b1, 10'b1000000000, DFF);
    chk("wr_mem128", 128'(dut0.Memory[128]), 128'hFF);
    chk("wr_mem131", 128'(dut0.Memory[131]), 128'hDD);
    chk("wr_echo", rd0, DFF);
    txn0(1'b0, 10'b1000001100, 128'd0);
    chk("rd_offset", rd0, DFF);

    // Preload block 3, then hold valid with wandering addresses.
    txn0(1'b1, 10'h030, DA);
    v0 = 1'b1; w0 = 1'b0; a0 = 10'h030;
    step();
    for (int i = 1; i <= 11; i++) begin
      a0 = 10'h040 + 10'(i * 16);
      if (i == 5) a0 = 10'h200;
      if (i >= 5) a0 = 10'h200;
      step();
      if (i == 6) v0 = 1'b0;
      chk($sformatf("hold_resp_%0d", i), 128'(rv0),
          128'(i == 4 || i == 10));
      chk($sformatf("hold_ready_%0d", i), 128'(rdy0),
          128'(i == 5 || i == 11));
      if (i == 4)  chk("hold_rdata1", rd0, DA);
      if (i == 10) chk("hold_rdata2", rd0, DFF);
    end

    // Reset in BUSY drops a write to block 5.
    v0 = 1'b1; w0 = 1'b1; a0 = 10'h050; d0 = D5;
    step();
    v0 = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ready", 128'(rdy0), 128'd1);
    chk("abort_resp", 128'(rv0), 128'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("abort_noresp_%0d", i), 128'(rv0), 128'd0);
    end
    for (int k = 20; k < 24; k++) begin
      chk($sformatf("abort_mem%0d", k),
          128'(dut0.Memory[k]), 128'd0);
    end

    // LATENCY=1: write then back-to-back read of the same block.
    chk("l1_ready0", 128'(rdy1), 128'd1);
    v1 = 1'b1; w1 = 1'b1; a1 = 10'h020; d1 = DX;
    step();
    w1 = 1'b0; d1 = '0;
    chk("l1_t0_ready", 128'(rdy1), 128'd0);
    chk("l1_t0_resp", 128'(rv1), 128'd0);
    step();
    chk("l1_t1_resp", 128'(rv1), 128'd1);
    chk("l1_t1_ready", 128'(rdy1), 128'd0);
    chk("l1_t1_rdata", rd1, DX);
    step();
    chk("l1_t2_resp", 128'(rv1), 128'd0);
    chk("l1_t2_ready", 128'(rdy1), 128'd1);
    step();
    v1 = 1'b0;
    chk("l1_t3_ready", 128'(rdy1), 128'd0);
    step();
    chk("l1_t4_resp", 128'(rv1), 128'd1);
    chk("l1_t4_rdata", rd1, DX);
    chk("l1_mem8", 128'(dut1.Memory[8]), 128'hFEEDFACE);
    step();
    chk("l1_t5_ready", 128'(rdy1), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
